// File: rtl/segre_decode_buf_if.sv
// segre_decode_buf_if: decode-stage types plus the fetch/decode bundle interface.
package segre_pkg;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,
    ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU, ALU_COPY_B
  } alu_opcode_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} memop_data_type_e;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

interface segre_decode_buf_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int DEPTH     = 4
);
  import segre_pkg::*;
  logic                     instr_valid_i;
  logic                     instr_ready_o;
  logic [WORD_SIZE-1:0]     instr_i;
  logic [WORD_SIZE-1:0]     pc_i;
  logic                     flush_i;
  logic                     dec_valid_o;
  logic                     dec_ready_i;
  logic [WORD_SIZE-1:0]     pc_o;
  logic [REG_SIZE-1:0]      raddr_a_o;
  logic [REG_SIZE-1:0]      raddr_b_o;
  logic [REG_SIZE-1:0]      waddr_o;
  logic                     rd_raddr_a_o;
  logic                     rd_raddr_b_o;
  logic                     rf_we_o;
  logic [WORD_SIZE-1:0]     imm_o;
  alu_opcode_e              alu_opcode_o;
  logic                     memop_rd_o;
  logic                     memop_wr_o;
  memop_data_type_e         memop_type_o;
  logic                     memop_sign_ext_o;
  logic                     mext_o;
  logic [2:0]               mext_op_o;
  logic                     illegal_o;
  logic [$clog2(DEPTH):0]   count_o;
  modport master (
    output instr_valid_i, instr_i, pc_i, flush_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, pc_o, raddr_a_o, raddr_b_o, waddr_o, rd_raddr_a_o,
           rd_raddr_b_o, rf_we_o, imm_o, alu_opcode_o, memop_rd_o, memop_wr_o, memop_type_o,
           memop_sign_ext_o, mext_o, mext_op_o, illegal_o, count_o
  );
  modport slave (
    input  instr_valid_i, instr_i, pc_i, flush_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, pc_o, raddr_a_o, raddr_b_o, waddr_o, rd_raddr_a_o,
           rd_raddr_b_o, rf_we_o, imm_o, alu_opcode_o, memop_rd_o, memop_wr_o, memop_type_o,
           memop_sign_ext_o, mext_o, mext_op_o, illegal_o, count_o
  );
endinterface

// File: rtl/segre_decode_buf.sv
// segre_decode_buf: instruction FIFO feeding an RV32I(+M) decoder with a registered output bundle.
module segre_decode_buf
  import segre_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter int DEPTH     = 4,
  parameter int M_EXT     = 0
) (
  input logic clk_i,
  input logic rsn_i,
  segre_decode_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [2*WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   push, pop;
  logic [WORD_SIZE-1:0]   ins, pc_h;
  logic [6:0]             opc, f7;
  logic [2:0]             f3;
  logic [WORD_SIZE-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  alu_opcode_e            alu_arith, alu_branch;
  logic [WORD_SIZE-1:0]   d_imm;
  alu_opcode_e            d_alu;
  logic                   d_we, d_ra, d_rb, d_rd, d_wr, d_sext, d_mext, d_ill;
  memop_data_type_e       d_type, size_f3;
  logic                   dec_valid;
  logic [WORD_SIZE-1:0]   pc_q, imm_q;
  logic [REG_SIZE-1:0]    ra_q, rb_q, wa_q;
  logic                   rra_q, rrb_q, we_q, mrd_q, mwr_q, sext_q, mext_q, ill_q;
  logic [2:0]             mop_q;
  alu_opcode_e            alu_q;
  memop_data_type_e       type_q;
  assign bus.instr_ready_o = count != (AW+1)'(DEPTH);
  assign push = !bus.flush_i && bus.instr_valid_i && bus.instr_ready_o;
  assign pop  = !bus.flush_i && count != '0 && (!dec_valid || bus.dec_ready_i);
  assign {ins, pc_h} = mem[rd_ptr];
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= {bus.instr_i, bus.pc_i};
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = WORD_SIZE'($signed(ins[31:20]));
  assign imm_s = WORD_SIZE'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = WORD_SIZE'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = WORD_SIZE'($signed({ins[31:12], 12'b0}));
  assign imm_j = WORD_SIZE'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  assign size_f3 = f3[1:0] == 2'b00 ? BYTE : f3[1:0] == 2'b01 ? HALF : WORD;
  // bit 30 selects SUB/SRA; ADDI ignores it because it is part of the immediate there
  always_comb begin
    alu_arith = f3 == 3'b000 ? (opc == OPC_OP && ins[30] ? ALU_SUB : ALU_ADD) :
                f3 == 3'b001 ? ALU_SLL  :
                f3 == 3'b010 ? ALU_SLT  :
                f3 == 3'b011 ? ALU_SLTU :
                f3 == 3'b100 ? ALU_XOR  :
                f3 == 3'b101 ? (ins[30] ? ALU_SRA : ALU_SRL) :
                f3 == 3'b110 ? ALU_OR   : ALU_AND;
    alu_branch = f3 == 3'b000 ? ALU_EQ  :
                 f3 == 3'b001 ? ALU_NE  :
                 f3 == 3'b100 ? ALU_LT  :
                 f3 == 3'b101 ? ALU_GE  :
                 f3 == 3'b110 ? ALU_LTU :
                 f3 == 3'b111 ? ALU_GEU : ALU_ADD;
  end
  always_comb begin
    d_imm  = '0;
    d_alu  = ALU_ADD;
    d_we   = 1'b0;
    d_ra   = 1'b0;
    d_rb   = 1'b0;
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    d_type = WORD;
    d_sext = 1'b0;
    d_mext = 1'b0;
    d_ill  = 1'b0;
    case (opc)
      OPC_LUI: begin
        d_imm = imm_u;
        d_alu = ALU_COPY_B;
        d_we  = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = imm_u;
        d_we  = 1'b1;
      end
      OPC_JAL: begin
        d_imm = imm_j;
        d_we  = 1'b1;
      end
      OPC_JALR: begin
        d_imm = imm_i;
        d_we  = 1'b1;
        d_ra  = 1'b1;
        d_ill = f3 != 3'b000;
      end
      OPC_OP_IMM: begin
        d_imm = imm_i;
        d_alu = alu_arith;
        d_we  = 1'b1;
        d_ra  = 1'b1;
        d_ill = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      OPC_OP: begin
        d_we = 1'b1;
        d_ra = 1'b1;
        d_rb = 1'b1;
        if (f7 == 7'b0000001) begin
          d_mext = M_EXT != 0;
          d_ill  = M_EXT == 0;
        end else begin
          d_alu = alu_arith;
          d_ill = f7 != 7'b0 && !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        end
      end
      OPC_LOAD: begin
        d_imm  = imm_i;
        d_we   = 1'b1;
        d_ra   = 1'b1;
        d_rd   = 1'b1;
        d_type = size_f3;
        d_sext = ~f3[2];
        d_ill  = f3[1:0] == 2'b11 || f3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        d_imm  = imm_s;
        d_ra   = 1'b1;
        d_rb   = 1'b1;
        d_wr   = 1'b1;
        d_type = size_f3;
        d_ill  = f3 >= 3'b011;
      end
      OPC_BRANCH: begin
        d_imm = imm_b;
        d_alu = alu_branch;
        d_ra  = 1'b1;
        d_rb  = 1'b1;
        d_ill = f3[2:1] == 2'b01;
      end
      default: d_ill = 1'b1;
    endcase
    // an illegal bundle must have no architectural side effect downstream
    if (d_ill) begin
      d_alu  = ALU_ADD;
      d_we   = 1'b0;
      d_rd   = 1'b0;
      d_wr   = 1'b0;
      d_type = WORD;
      d_sext = 1'b0;
      d_mext = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      dec_valid <= 1'b0;
      pc_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      wa_q      <= '0;
      rra_q     <= 1'b0;
      rrb_q     <= 1'b0;
      we_q      <= 1'b0;
      imm_q     <= '0;
      alu_q     <= ALU_ADD;
      mrd_q     <= 1'b0;
      mwr_q     <= 1'b0;
      type_q    <= WORD;
      sext_q    <= 1'b0;
      mext_q    <= 1'b0;
      mop_q     <= '0;
      ill_q     <= 1'b0;
    end else begin
      dec_valid <= bus.flush_i ? 1'b0 : pop ? 1'b1 : bus.dec_ready_i ? 1'b0 : dec_valid;
      if (pop) begin
        pc_q   <= pc_h;
        ra_q   <= REG_SIZE'(ins[19:15]);
        rb_q   <= REG_SIZE'(ins[24:20]);
        wa_q   <= REG_SIZE'(ins[11:7]);
        rra_q  <= d_ra;
        rrb_q  <= d_rb;
        we_q   <= d_we;
        imm_q  <= d_imm;
        alu_q  <= d_alu;
        mrd_q  <= d_rd;
        mwr_q  <= d_wr;
        type_q <= d_type;
        sext_q <= d_sext;
        mext_q <= d_mext;
        mop_q  <= d_mext ? f3 : 3'b000;
        ill_q  <= d_ill;
      end
    end
  assign bus.count_o          = count;
  assign bus.dec_valid_o      = dec_valid;
  assign bus.pc_o             = pc_q;
  assign bus.raddr_a_o        = ra_q;
  assign bus.raddr_b_o        = rb_q;
  assign bus.waddr_o          = wa_q;
  assign bus.rd_raddr_a_o     = rra_q;
  assign bus.rd_raddr_b_o     = rrb_q;
  assign bus.rf_we_o          = we_q;
  assign bus.imm_o            = imm_q;
  assign bus.alu_opcode_o     = alu_q;
  assign bus.memop_rd_o       = mrd_q;
  assign bus.memop_wr_o       = mwr_q;
  assign bus.memop_type_o     = type_q;
  assign bus.memop_sign_ext_o = sext_q;
  assign bus.mext_o           = mext_q;
  assign bus.mext_op_o        = mop_q;
  assign bus.illegal_o        = ill_q;
endmodule

// File: tb/tb_segre_decode_buf.sv
// tb_segre_decode_buf: random and directed stimulus against a queue-based reference, M_EXT=0 and M_EXT=1 side by side.
module tb_segre_decode_buf;
  import segre_pkg::*;
  localparam logic [96:0] RST_BUN = {89'b0, 2'd2, 6'b0};
  logic clk = 1'b0;
  logic rsn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] q[$];
  bit          mv;
  logic [63:0] mo;
  logic [96:0] bun0, bun1;
  logic [31:0] w[6];
  segre_decode_buf_if #(.WORD_SIZE(32), .REG_SIZE(5), .DEPTH(4)) b0 ();
  segre_decode_buf_if #(.WORD_SIZE(32), .REG_SIZE(5), .DEPTH(4)) b1 ();
  segre_decode_buf #(.WORD_SIZE(32), .REG_SIZE(5), .DEPTH(4), .M_EXT(0)) dut0 (.clk_i(clk), .rsn_i(rsn), .bus(b0));
  segre_decode_buf #(.WORD_SIZE(32), .REG_SIZE(5), .DEPTH(4), .M_EXT(1)) dut1 (.clk_i(clk), .rsn_i(rsn), .bus(b1));
  always #5 clk = ~clk;
  assign bun0 = {b0.pc_o, b0.raddr_a_o, b0.raddr_b_o, b0.waddr_o, b0.rd_raddr_a_o, b0.rd_raddr_b_o,
                 b0.rf_we_o, b0.imm_o, 5'(b0.alu_opcode_o), b0.memop_rd_o, b0.memop_wr_o,
                 2'(b0.memop_type_o), b0.memop_sign_ext_o, b0.mext_o, b0.mext_op_o, b0.illegal_o};
  assign bun1 = {b1.pc_o, b1.raddr_a_o, b1.raddr_b_o, b1.waddr_o, b1.rd_raddr_a_o, b1.rd_raddr_b_o,
                 b1.rf_we_o, b1.imm_o, 5'(b1.alu_opcode_o), b1.memop_rd_o, b1.memop_wr_o,
                 2'(b1.memop_type_o), b1.memop_sign_ext_o, b1.mext_o, b1.mext_op_o, b1.illegal_o};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // expected decoded bundle straight from the RV32I/M field rules
  function automatic logic [96:0] dec(input logic [31:0] ins, input logic [31:0] pc, input bit m);
    alu_opcode_e      ar[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_opcode_e      br[8] = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    memop_data_type_e sz[4] = '{BYTE, HALF, WORD, WORD};
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] ui = {ins[31:12], 12'b0};
    logic [31:0] ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic ok = 1, we = 0, ra = 0, rb = 0, mrd = 0, mwr = 0, sext = 0, mx = 0;
    logic [31:0] imm = 0;
    alu_opcode_e alu = ALU_ADD;
    memop_data_type_e mt = WORD;
    case (ins[6:0])
      OPC_LUI:    begin we = 1; imm = ui; alu = ALU_COPY_B; end
      OPC_AUIPC:  begin we = 1; imm = ui; end
      OPC_JAL:    begin we = 1; imm = ji; end
      OPC_JALR:   begin we = 1; ra = 1; imm = ii; ok = f3 == 0; end
      OPC_OP_IMM: begin
        we = 1; ra = 1; imm = ii;
        alu = (f3 == 5 && ins[30]) ? ALU_SRA : ar[f3];
        ok = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1;
      end
      OPC_OP: begin
        we = 1; ra = 1; rb = 1;
        if (f7 == 7'h01) begin ok = m; mx = m; end
        else begin
          alu = f7 == 7'h20 ? (f3 == 0 ? ALU_SUB : ALU_SRA) : ar[f3];
          ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        end
      end
      OPC_LOAD:   begin we = 1; ra = 1; mrd = 1; imm = ii; mt = sz[f3[1:0]]; sext = !f3[2]; ok = f3 != 3 && f3 < 6; end
      OPC_STORE:  begin ra = 1; rb = 1; mwr = 1; imm = si; mt = sz[f3[1:0]]; ok = f3 < 3; end
      OPC_BRANCH: begin ra = 1; rb = 1; imm = bi; alu = br[f3]; ok = f3 != 2 && f3 != 3; end
      default:    ok = 0;
    endcase
    if (!ok) begin we = 0; mrd = 0; mwr = 0; mx = 0; mt = WORD; sext = 0; alu = ALU_ADD; end
    return {pc, ins[19:15], ins[24:20], ins[11:7], ra, rb, we, imm, 5'(alu), mrd, mwr, 2'(mt), sext, mx,
            mx ? f3 : 3'b0, !ok};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] opcs[9] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h7f};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 10);
    r[6:0]   = k > 8 ? 7'($urandom) : opcs[k];
    r[31:25] = $urandom_range(0, 4) == 4 ? 7'($urandom) : f7s[$urandom_range(0, 3)];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    mv = 0;
  endtask

  task automatic compare();
    check("count0", b0.count_o, q.size());
    check("count1", b1.count_o, q.size());
    check("ready0", b0.instr_ready_o, q.size() != 4);
    check("valid0", b0.dec_valid_o, mv);
    check("valid1", b1.dec_valid_o, mv);
    if (mv) begin
      check("bundle_m0", bun0, dec(mo[63:32], mo[31:0], 0));
      check("bundle_m1", bun1, dec(mo[63:32], mo[31:0], 1));
    end
  endtask

  // drive at negedge, advance the reference, check at the next negedge
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit r, input bit f);
    bit push;
    b0.instr_valid_i = v; b0.instr_i = ins; b0.pc_i = pc; b0.dec_ready_i = r; b0.flush_i = f;
    b1.instr_valid_i = v; b1.instr_i = ins; b1.pc_i = pc; b1.dec_ready_i = r; b1.flush_i = f;
    push = v && q.size() != 4 && !f;
    if (f) model_reset();
    else begin
      if (q.size() != 0 && (!mv || r)) begin mo = q.pop_front(); mv = 1; end
      else if (r) mv = 0;
      if (push) q.push_back({ins, pc});
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    cyc_init();
  end

  task automatic cyc_init();
    b0.instr_valid_i = 0; b0.instr_i = 0; b0.pc_i = 0; b0.dec_ready_i = 0; b0.flush_i = 0;
    b1.instr_valid_i = 0; b1.instr_i = 0; b1.pc_i = 0; b1.dec_ready_i = 0; b1.flush_i = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_bundle_held", bun0, RST_BUN);
    rsn = 1;
    #1;
    compare();
    check("rst_bundle", bun1, RST_BUN);
    @(negedge clk);
    // ADDI x1,x0,5: two-edge latency
    cyc(1, 32'h00500093, 32'h100, 1, 0);
    check("addi_lat1", b0.dec_valid_o, 0);
    cyc(0, 0, 0, 1, 0);
    check("addi_valid", b0.dec_valid_o, 1);
    check("addi_waddr", b0.waddr_o, 1);
    check("addi_imm", b0.imm_o, 5);
    check("addi_we", b0.rf_we_o, 1);
    check("addi_ill", b0.illegal_o, 0);
    cyc(0, 0, 0, 1, 0);
    // fill with consumer stalled, then drain in order
    foreach (w[i]) w[i] = rnd_instr();
    for (int i = 0; i < 6; i++) cyc(1, w[i], 32'h200 + 4 * i, 0, 0);
    check("full_count", b0.count_o, 4);
    check("full_ready", b0.instr_ready_o, 0);
    check("full_head_pc", b0.pc_o, 32'h200);
    cyc(1, w[5], 32'h214, 1, 0);
    cyc(1, w[5], 32'h214, 1, 0);
    repeat (7) cyc(0, 0, 0, 1, 0);
    // LH x2,0(x3) then SB x2,0(x3)
    cyc(1, 32'h00019103, 32'h300, 1, 0);
    cyc(1, 32'h00218023, 32'h304, 1, 0);
    check("lh_type", b0.memop_type_o, HALF);
    check("lh_sext", b0.memop_sign_ext_o, 1);
    check("lh_we", b0.rf_we_o, 1);
    cyc(0, 0, 0, 1, 0);
    check("sb_type", b0.memop_type_o, BYTE);
    check("sb_wr", b0.memop_wr_o, 1);
    check("sb_we", b0.rf_we_o, 0);
    cyc(0, 0, 0, 1, 0);
    // MUL with and without the M extension
    cyc(1, 32'h02208033, 32'h400, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("mul_m0_ill", b0.illegal_o, 1);
    check("mul_m0_we", b0.rf_we_o, 0);
    check("mul_m1_mext", b1.mext_o, 1);
    check("mul_m1_op", b1.mext_op_o, 0);
    check("mul_m1_ill", b1.illegal_o, 0);
    cyc(0, 0, 0, 1, 0);
    // flush with three buffered and a same-cycle push
    for (int i = 0; i < 4; i++) cyc(1, rnd_instr(), 32'h500 + 4 * i, 0, 0);
    check("pre_flush_count", b0.count_o, 3);
    cyc(1, rnd_instr(), 32'h510, 0, 1);
    check("flush_count", b0.count_o, 0);
    check("flush_valid", b0.dec_valid_o, 0);
    cyc(0, 0, 0, 1, 0);
    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1, rnd_instr(), 32'h600 + 4 * i, 0, 0);
    b0.instr_valid_i = 0;
    b1.instr_valid_i = 0;
    #2 rsn = 0;
    #1;
    model_reset();
    check("arst_count", b0.count_o, 0);
    check("arst_valid", b0.dec_valid_o, 0);
    check("arst_bundle", bun0, RST_BUN);
    check("arst_ready", b0.instr_ready_o, 1);
    @(negedge clk);
    #2 rsn = 1;
    @(negedge clk);
    cyc(1, 32'h00500093, 32'h700, 1, 0);
    check("post_rst_lat1", b0.dec_valid_o, 0);
    cyc(0, 0, 0, 1, 0);
    check("post_rst_valid", b0.dec_valid_o, 1);
    check("post_rst_pc", b0.pc_o, 32'h700);
    // random traffic
    repeat (800) cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask
endmodule
